axis_wrr_sched: RTL and testbench

Weighted round-robin packet scheduler that owns the port-select decision for the 3-input AXI4-Stream switch datapath. It watches per-port TVALID and the output handshake. It issues a registered one-hot grant that holds for whole packets. A grant may stay on one port for up to a configured number of consecutive packets, then rotates. The switch mux uses `grant_o` directly in place of its own arbitration, so packets are never interleaved.

---
 rtl/axis_sw_pkg.sv | 32 +++
 rtl/axis_rr_pick.sv | 38 +++
 rtl/axis_wrr_sched.sv | 140 ++++++++++++++
 tb/tb_axis_wrr_sched.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/axis_sw_pkg.sv
// Shared types and helpers for the AXI4-Stream switch: port count, scheduler states,
// and one-hot/index conversion used by the scheduler and the switch datapath.
package axis_sw_pkg;

  localparam int unsigned NUM_IN_DEF = 3;
  localparam int unsigned MAX_PORTS  = 16;
  localparam int unsigned MAX_IDX_W  = $clog2(MAX_PORTS);
  localparam int unsigned IDX_W_DEF  = $clog2(NUM_IN_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

  // Callers zero-extend narrower one-hot vectors; an all-zero input yields index 0.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAX_PORTS-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_PORTS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational rotate-priority picker: first eligible port after rr_ptr_i,
// wrapping modulo N, with rr_ptr_i itself searched last.
module axis_rr_pick
  import axis_sw_pkg::*;
#(
  parameter int unsigned N  = NUM_IN_DEF,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [N-1:0]  pick_oh_o,
  output logic [IW-1:0] pick_idx_o,
  output logic          any_o
);

  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          found;
    found      = 1'b0;
    pick_idx_o = '0;
    sum        = '0;
    cand       = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      // Sum stays below 2*N, so a single conditional subtract implements the modulo.
      sum = {1'b0, rr_ptr_i} + (IW+1)'(off);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!found && elig_i[cand]) begin
        found      = 1'b1;
        pick_idx_o = cand;
      end
    end
    any_o     = found;
    pick_oh_o = found ? N'(idx_to_onehot(MAX_IDX_W'(pick_idx_o))) : '0;
  end

endmodule

// File: rtl/axis_wrr_sched.sv
// Weighted round-robin packet scheduler: holds a registered one-hot grant for whole
// packets, up to a per-port number of consecutive packets, with a beat watchdog.
module axis_wrr_sched
  import axis_sw_pkg::*;
#(
  parameter int unsigned NUM_IN    = NUM_IN_DEF,
  parameter int unsigned WEIGHT_W  = 4,
  parameter int unsigned MAX_BEATS = 256,
  localparam int unsigned IDX_W    = $clog2(NUM_IN),
  localparam int unsigned BEAT_W   = $clog2(MAX_BEATS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            req_valid_i,
  input  logic [NUM_IN-1:0]            req_mask_i,
  input  logic [NUM_IN*WEIGHT_W-1:0]   weight_i,
  input  logic                         beat_fire_i,
  input  logic                         beat_last_i,
  output logic [NUM_IN-1:0]            grant_o,
  output logic [IDX_W-1:0]             grant_idx_o,
  output logic                         grant_active_o,
  output logic                         err_o
);

  sched_state_e          state_q, state_d;
  logic [NUM_IN-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;

  logic [NUM_IN-1:0]     eligible;
  logic [NUM_IN-1:0]     pick_elig;
  logic [NUM_IN-1:0]     pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [WEIGHT_W-1:0]   pick_weight;
  logic [WEIGHT_W-1:0]   pick_credit;
  logic                  cur_elig;
  logic                  wd_hit;

  assign eligible = req_valid_i & ~req_mask_i;
  assign cur_elig = |(eligible & grant_q);

  // A last beat on the watchdog beat is a normal end of packet, so TLAST masks the hit.
  assign wd_hit = (state_q == BUSY) && beat_fire_i && !beat_last_i &&
                  (beat_cnt_q == BEAT_W'(MAX_BEATS - 1));

  assign pick_elig = wd_hit ? (eligible & ~grant_q) : eligible;

  axis_rr_pick #(
    .N (NUM_IN)
  ) u_pick (
    .elig_i     (pick_elig),
    .rr_ptr_i   (rr_ptr_q),
    .pick_oh_o  (pick_oh),
    .pick_idx_o (pick_idx),
    .any_o      (pick_any)
  );

  always_comb begin
    pick_weight = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (pick_idx == IDX_W'(i)) pick_weight = weight_i[i*WEIGHT_W +: WEIGHT_W];
    end
    pick_credit = (pick_weight == '0) ? '0 : pick_weight - WEIGHT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    credit_d   = credit_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat_fire_i) err_d = 1'b1;
        if (pick_any) begin
          state_d    = BUSY;
          grant_d    = pick_oh;
          idx_d      = pick_idx;
          rr_ptr_d   = pick_idx;
          credit_d   = pick_credit;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        if (beat_fire_i) begin
          if (beat_last_i || wd_hit) begin
            beat_cnt_d = '0;
            err_d      = wd_hit;
            if (!wd_hit && (credit_q != '0) && cur_elig) begin
              credit_d = credit_q - WEIGHT_W'(1);
            end else if (pick_any) begin
              grant_d  = pick_oh;
              idx_d    = pick_idx;
              rr_ptr_d = pick_idx;
              credit_d = pick_credit;
            end else begin
              state_d  = IDLE;
              grant_d  = '0;
              credit_d = '0;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      rr_ptr_q   <= IDX_W'(NUM_IN - 1);
      credit_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      credit_q   <= credit_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign grant_o        = grant_q;
  assign grant_idx_o    = idx_q;
  assign grant_active_o = |grant_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_axis_wrr_sched.sv
// Scoreboard bench for axis_wrr_sched: a packet-level reference model predicts the
// grant/error outputs per cycle; a negedge monitor pops and compares.
module tb_axis_wrr_sched;

  localparam int N  = 3;
  localparam int WW = 4;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid, req_mask;
  logic [11:0] weight;
  logic        fire, last;
  logic [2:0]  grant;
  logic [1:0]  gidx;
  logic        gact, err;

  always #5 clk = ~clk;

  axis_wrr_sched #(
    .NUM_IN    (N),
    .WEIGHT_W  (WW),
    .MAX_BEATS (MB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_mask_i     (req_mask),
    .weight_i       (weight),
    .beat_fire_i    (fire),
    .beat_last_i    (last),
    .grant_o        (grant),
    .grant_idx_o    (gidx),
    .grant_active_o (gact),
    .err_o          (err)
  );

  typedef struct packed {
    logic [2:0] grant;
    logic [1:0] idx;
    logic       act;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: current owner (-1 = none), packets left in the turn, beats seen.
  int m_cur, m_credit, m_beats, m_rr, m_idx;
  bit m_err;
  int wt[3];

  function automatic int model_pick(input logic [2:0] e);
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (m_rr + k) % N;
      if (e[p]) return p;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_cur = -1; m_credit = 0; m_beats = 0; m_rr = N - 1; m_idx = 0; m_err = 0;
  endfunction

  function automatic void model_grant(input int p);
    m_cur = p; m_rr = p; m_idx = p; m_beats = 0;
    m_credit = ((wt[p] == 0) ? 1 : wt[p]) - 1;
  endfunction

  function automatic void model_step(input logic [2:0] e_in, input logic f, input logic l);
    int p;
    bit wd;
    logic [2:0] e;
    e = e_in;
    m_err = 0;
    if (m_cur < 0) begin
      if (f) m_err = 1;
      p = model_pick(e);
      if (p >= 0) model_grant(p);
    end else if (f) begin
      wd = !l && (m_beats + 1 == MB);
      if (l || wd) begin
        m_beats = 0;
        if (wd) begin
          m_err = 1; m_credit = 0; e[m_cur] = 1'b0;
        end
        if (m_credit > 0 && e[m_cur]) m_credit--;
        else begin
          p = model_pick(e);
          if (p >= 0) model_grant(p);
          else m_cur = -1;
        end
      end else begin
        m_beats++;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t o;
    o.grant = (m_cur >= 0) ? 3'(1 << m_cur) : 3'b000;
    o.idx   = 2'(m_idx);
    o.act   = (m_cur >= 0);
    o.err   = m_err;
    return o;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_tests++;
      if ({grant, gidx, gact, err} !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got grant=%b idx=%0d act=%b err=%b, want grant=%b idx=%0d act=%b err=%b",
                 $time, grant, gidx, gact, err, e.grant, e.idx, e.act, e.err);
      end
    end
  end

  task automatic cycle(input logic [2:0] v, input logic [2:0] m, input logic f, input logic l);
    @(negedge clk); #1;
    rst = 1'b0;
    req_valid = v; req_mask = m; fire = f; last = l;
    weight = {4'(wt[2]), 4'(wt[1]), 4'(wt[0])};
    model_step(v & ~m, f, l);
    sb_q.push_back(model_out());
  endtask

  task automatic reset_mid();
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (grant !== 3'b000 || gact !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got grant=%b act=%b, want grant=000 act=0", grant, gact);
    end
    sb_q.delete();
    model_reset();
    sb_q.push_back(model_out());
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_mask = '0; fire = 1'b0; last = 1'b0;
    wt[0] = 1; wt[1] = 1; wt[2] = 1;
    weight = {4'(wt[2]), 4'(wt[1]), 4'(wt[0])};
    model_reset();
    sb_q.push_back(model_out());

    // Port 0 alone, single-beat packets, weight 1: back-to-back grants.
    repeat (6) cycle(3'b001, 3'b000, m_cur >= 0, 1'b1);
    // All valid, weights 1, two-beat packets: plain rotation.
    repeat (14) cycle(3'b111, 3'b000, m_cur >= 0, m_beats == 1);
    // Weights {3,1,2}.
    wt[0] = 3; wt[1] = 1; wt[2] = 2;
    repeat (30) cycle(3'b111, 3'b000, m_cur >= 0, m_beats == 1);
    // Mask port 1, then unmask.
    repeat (20) cycle(3'b111, 3'b010, m_cur >= 0, m_beats == 1);
    repeat (10) cycle(3'b111, 3'b000, m_cur >= 0, m_beats == 1);
    // Runaway packets: watchdog handover between ports 0 and 2.
    wt[0] = 1; wt[1] = 1; wt[2] = 1;
    repeat (20) cycle(3'b101, 3'b000, m_cur >= 0, 1'b0);
    // Nothing eligible; beats keep firing until watchdog, then into IDLE.
    repeat (8) cycle(3'b000, 3'b000, 1'b1, 1'b0);
    // Reset mid-packet, then all valid.
    repeat (3) cycle(3'b111, 3'b000, m_cur >= 0, 1'b0);
    reset_mid();
    repeat (6) cycle(3'b111, 3'b000, m_cur >= 0, m_beats == 1);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] v, m;
      logic f, l;
      if ($urandom_range(0, 49) == 0) begin
        for (int p = 0; p < N; p++) wt[p] = $urandom_range(0, 15);
      end
      if ($urandom_range(0, 499) == 0) reset_mid();
      v = 3'($urandom);
      m = 3'($urandom & $urandom & $urandom);
      f = (m_cur >= 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 2) == 0);
      cycle(v, m, f, l);
    end

    @(negedge clk); #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
